// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss engine for the set-associative cache.
// On a miss it writes back the dirty victim line, refills the line word by
// word from memory, writes the new tag and strobes Init so the replacement
// controller updates its LRU state. The pipeline is stalled throughout.
module cache_refill_ctrl #(
    parameter  int LOGW = 2,
    parameter  int IDXW = 4,
    localparam int TAGW = 30 - LOGW - IDXW
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Req,
    input  logic [31:0]     Addr,
    input  logic            Hit,
    input  logic [1:0]      Victim,
    input  logic            VDirty,
    input  logic [TAGW-1:0] VTag,
    input  logic [31:0]     LineRData,
    input  logic            MemReady,
    input  logic [31:0]     MemRData,
    output logic            Stall,
    output logic            MemRead,
    output logic            MemWrite,
    output logic [31:0]     MemAddr,
    output logic [31:0]     MemWData,
    output logic [LOGW-1:0] WordIdx,
    output logic [1:0]      FillWay,
    output logic            FillWe,
    output logic [31:0]     FillData,
    output logic            TagWe,
    output logic            Init
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WB     = 2'd1,
        S_FILL   = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t          r_state;
    logic [29:LOGW]  r_line_addr;   // line address (word address without word offset)
    logic [1:0]      r_fill_way;
    logic [TAGW-1:0] r_wb_tag;
    logic [LOGW-1:0] r_word_idx;

    logic            w_miss;
    logic            w_last;
    logic [IDXW-1:0] w_index;
    logic            w_unused;

    assign w_miss   = Req & ~Hit;
    assign w_last   = (r_word_idx == {LOGW{1'b1}});
    assign w_index  = r_line_addr[LOGW+IDXW-1:LOGW];
    // Byte and word offset of the access are irrelevant: whole lines move.
    assign w_unused = ^Addr[LOGW+1:0];

    assign WordIdx  = r_word_idx;
    assign FillWay  = r_fill_way;
    assign FillData = MemRData;

    // Miss sequencing: latch the miss context in IDLE, step words on MemReady.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_line_addr <= '0;
            r_fill_way  <= '0;
            r_wb_tag    <= '0;
            r_word_idx  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_line_addr <= Addr[31:LOGW+2];
                        r_fill_way  <= Victim;
                        r_wb_tag    <= VTag;
                        r_word_idx  <= '0;
                        r_state     <= VDirty ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    if (MemReady) begin
                        // Wraps to 0 on the last word, so FILL starts at word 0.
                        r_word_idx <= r_word_idx + LOGW'(1);
                        if (w_last) r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (MemReady) begin
                        r_word_idx <= r_word_idx + LOGW'(1);
                        if (w_last) r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Output decode from state; IDLE strobes are gated so reset forces all low.
    always_comb begin
        Stall    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemAddr  = '0;
        MemWData = '0;
        FillWe   = 1'b0;
        TagWe    = 1'b0;
        Init     = 1'b0;
        case (r_state)
            S_IDLE: begin
                Stall = w_miss & Reset;
                Init  = Req & Hit & Reset;
            end
            S_WB: begin
                Stall    = 1'b1;
                MemWrite = 1'b1;
                MemAddr  = {r_wb_tag, w_index, r_word_idx, 2'b00};
                MemWData = LineRData;
            end
            S_FILL: begin
                Stall   = 1'b1;
                MemRead = 1'b1;
                MemAddr = {r_line_addr, r_word_idx, 2'b00};
                FillWe  = MemReady;
            end
            S_UPDATE: begin
                Stall = 1'b1;
                TagWe = 1'b1;
                Init  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: IDLE vector table, directed miss
// sequences (clean, dirty, wait states, reset, ignored inputs) and random misses
// checked against a transfer-list model of each miss.
module tb_cache_refill_ctrl;

    localparam int LOGW       = 2;
    localparam int IDXW       = 4;
    localparam int TAGW       = 30 - LOGW - IDXW;
    localparam int WPL        = 1 << LOGW;
    localparam int LINE_BYTES = 4 * WPL;
    localparam int SET_SPAN   = LINE_BYTES << IDXW;

    logic            CLK = 1'b0;
    logic            Reset;
    logic            Req;
    logic [31:0]     Addr;
    logic            Hit;
    logic [1:0]      Victim;
    logic            VDirty;
    logic [TAGW-1:0] VTag;
    logic [31:0]     LineRData;
    logic            MemReady;
    logic [31:0]     MemRData;
    logic            Stall;
    logic            MemRead;
    logic            MemWrite;
    logic [31:0]     MemAddr;
    logic [31:0]     MemWData;
    logic [LOGW-1:0] WordIdx;
    logic [1:0]      FillWay;
    logic            FillWe;
    logic [31:0]     FillData;
    logic            TagWe;
    logic            Init;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        int          w;
    } xfer_t;

    typedef struct {
        logic req, hit, rdy, stall, init;
    } vec_t;

    cache_refill_ctrl #(.LOGW(LOGW), .IDXW(IDXW)) dut (
        .CLK(CLK), .Reset(Reset), .Req(Req), .Addr(Addr), .Hit(Hit),
        .Victim(Victim), .VDirty(VDirty), .VTag(VTag), .LineRData(LineRData),
        .MemReady(MemReady), .MemRData(MemRData), .Stall(Stall),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddr(MemAddr),
        .MemWData(MemWData), .WordIdx(WordIdx), .FillWay(FillWay),
        .FillWe(FillWe), .FillData(FillData), .TagWe(TagWe), .Init(Init)
    );

    always #5 CLK = ~CLK;

    // Cache array contents as seen by the engine: a distinct word per way/word.
    function automatic logic [31:0] line_word(input logic [1:0] way, input int w);
        return 32'hD0D0_0000 | (32'(way) << 8) | 32'(w);
    endfunction

    assign LineRData = line_word(FillWay, int'(WordIdx));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic int pick_wait(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 2;
        return $urandom_range(0, 3);
    endfunction

    // One complete miss starting from IDLE at posedge+1. The expected memory
    // traffic is a list of transfers; each MemReady retires the head.
    task automatic run_miss(input logic [31:0] addr, input logic [1:0] vic, input bit dirty,
                            input logic [TAGW-1:0] vtag, input int mode, input bit scramble,
                            output int rd_cycles);
        xfer_t       q[$];
        xfer_t       it;
        int          nwait, waited, tot_wait, stalls, cyc;
        bit          rdy;
        logic [31:0] base, wbase;
        base  = addr - (addr % LINE_BYTES);
        wbase = (32'(vtag) << (IDXW + LOGW + 2)) + (addr % SET_SPAN) - (addr % LINE_BYTES);
        if (dirty)
            for (int w = 0; w < WPL; w++) q.push_back('{1'b1, wbase + 32'(4 * w), w});
        for (int w = 0; w < WPL; w++) q.push_back('{1'b0, base + 32'(4 * w), w});

        Req = 1'b1; Hit = 1'b0; Addr = addr; Victim = vic; VDirty = dirty; VTag = vtag;
        MemReady = 1'b1; MemRData = $urandom;
        @(negedge CLK);
        chk("miss_stall", Stall, 1);
        chk("miss_idle_flags", {Init, MemRead, MemWrite, FillWe, TagWe}, 0);
        stalls = int'(Stall);
        rd_cycles = 0; tot_wait = 0; waited = 0; cyc = 0;
        nwait = pick_wait(mode);
        @(posedge CLK); #1;

        while (q.size() > 0 && cyc < 400) begin
            if (scramble) begin
                Req = 1'($urandom); Hit = 1'($urandom); Victim = 2'($urandom);
                VDirty = 1'($urandom); VTag = TAGW'($urandom); Addr = $urandom;
            end
            rdy = (waited >= nwait);
            MemReady = rdy; MemRData = $urandom;
            @(negedge CLK);
            it = q[0];
            chk("xfer_kind", {MemWrite, MemRead}, it.wr ? 2'b10 : 2'b01);
            chk("mem_addr", MemAddr, it.addr);
            chk("word_idx", WordIdx, it.w);
            chk("fill_way", FillWay, vic);
            if (it.wr) chk("wb_data", MemWData, line_word(vic, it.w));
            chk("fill_we", FillWe, !it.wr && rdy);
            chk("fill_data", FillData, MemRData);
            chk("busy_flags", {Stall, TagWe, Init}, 3'b100);
            stalls += int'(Stall);
            if (!it.wr) rd_cycles++;
            if (rdy) begin
                void'(q.pop_front());
                waited = 0;
                nwait = pick_wait(mode);
            end else begin
                waited++;
                tot_wait++;
            end
            cyc++;
            @(posedge CLK); #1;
        end
        if (q.size() != 0) chk("xfer_timeout", q.size(), 0);

        Req = 1'($urandom); Hit = 1'($urandom); MemReady = 1'($urandom);
        @(negedge CLK);
        chk("update_flags", {Stall, TagWe, Init, MemRead, MemWrite, FillWe}, 6'b111000);
        stalls += int'(Stall);
        @(posedge CLK); #1;

        Req = 1'b1; Hit = 1'b1; MemReady = 1'b1;
        @(negedge CLK);
        chk("retry_flags", {Stall, TagWe, Init, MemRead, MemWrite}, 5'b00100);
        chk("stall_cycles", stalls, 2 + WPL * (dirty ? 2 : 1) + tot_wait);
        @(posedge CLK); #1;
        Req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        int   rd;
        tbl[0] = '{1, 1, 0, 0, 1};
        tbl[1] = '{1, 1, 1, 0, 1};
        tbl[2] = '{1, 1, 1, 0, 1};
        tbl[3] = '{0, 0, 1, 0, 0};
        tbl[4] = '{0, 1, 0, 0, 0};
        tbl[5] = '{1, 0, 1, 1, 0};
        tbl[6] = '{1, 1, 0, 0, 1};

        Reset = 1'b0; Req = 1'b1; Hit = 1'b0; Addr = 32'h0000_1238; Victim = 2'd3;
        VDirty = 1'b1; VTag = '1; MemReady = 1'b1; MemRData = 32'h1357_9BDF;
        #2;
        chk("rst_flags", {Stall, MemRead, MemWrite, FillWe, TagWe, Init}, 0);
        chk("rst_addr", MemAddr, 0);
        chk("rst_wdata", MemWData, 0);
        chk("rst_word_way", {WordIdx, FillWay}, 0);
        chk("rst_fill_data", FillData, 32'h1357_9BDF);
        Req = 1'b0;
        @(posedge CLK); #1;
        Reset = 1'b1;
        @(posedge CLK); #1;

        // IDLE behaviour; a miss vector is withdrawn before the edge.
        foreach (tbl[i]) begin
            Req = tbl[i].req; Hit = tbl[i].hit; MemReady = tbl[i].rdy;
            @(negedge CLK);
            chk($sformatf("vec%0d_stall", i), Stall, tbl[i].stall);
            chk($sformatf("vec%0d_init", i), Init, tbl[i].init);
            chk($sformatf("vec%0d_quiet", i), {MemRead, MemWrite, FillWe, TagWe}, 0);
            if (tbl[i].req && !tbl[i].hit) Req = 1'b0;
            @(posedge CLK); #1;
        end
        Req = 1'b0;

        // Clean miss, zero-wait.
        run_miss(32'h0000_1238, 2'd2, 1'b0, 24'h000012, 0, 0, rd);
        chk("clean_fill_len", rd, WPL);
        // Dirty miss, victim tag differs from the access tag.
        run_miss(32'h0000_ABC4, 2'd1, 1'b1, 24'h5A5A5A, 0, 0, rd);
        chk("dirty_fill_len", rd, WPL);
        // Two wait cycles before each word.
        run_miss(32'h0000_2200, 2'd0, 1'b0, 24'h000022, 1, 0, rd);
        chk("wait_fill_len", rd, 12);
        // Dirty miss with waits and ignored inputs wiggling throughout.
        run_miss(32'h8000_00F0, 2'd3, 1'b1, 24'hC0FFEE, 1, 1, rd);
        chk("wait_dirty_fill_len", rd, 12);
        // Victim/VDirty/Addr change during the miss must not matter.
        run_miss(32'h0000_3310, 2'd2, 1'b0, 24'h000033, 0, 1, rd);

        // Reset in the middle of FILL.
        Req = 1'b1; Hit = 1'b0; Addr = 32'h0000_4560; Victim = 2'd3; VDirty = 1'b0;
        VTag = 24'h000045; MemReady = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("pre_reset_word", WordIdx, 2);
        chk("pre_reset_read", MemRead, 1);
        #1;
        Reset = 1'b0;
        #1;
        chk("midrst_flags", {Stall, MemRead, MemWrite, FillWe, TagWe, Init}, 0);
        chk("midrst_addr", MemAddr, 0);
        chk("midrst_wdata", MemWData, 0);
        chk("midrst_word_way", {WordIdx, FillWay}, 0);
        chk("midrst_fill_data", FillData, MemRData);
        @(posedge CLK); #1;
        chk("midrst_hold_flags", {Stall, MemRead, MemWrite, TagWe, Init}, 0);
        Req = 1'b0;
        Reset = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("post_rst_quiet", {Stall, TagWe, Init, MemRead, MemWrite}, 0);
        end
        @(posedge CLK); #1;
        run_miss(32'h0000_4560, 2'd1, 1'b0, 24'h000045, 0, 0, rd);

        // Random mix of hits and misses.
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                Req = 1'b1; Hit = 1'b1; MemReady = 1'($urandom);
                @(negedge CLK);
                chk("rand_hit", {Stall, Init, MemRead, MemWrite, TagWe}, 5'b01000);
                @(posedge CLK); #1;
                Req = 1'b0;
            end else begin
                run_miss($urandom, 2'($urandom), 1'($urandom), TAGW'($urandom), 2, 1, rd);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
